// File: rtl/serial_subtractor_pkg.sv
// Shared state encoding for the bit-serial subtractor.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Purely combinational, zero latency, no flow control.
module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first serial subtractor: first - second - bin, one bit per clock; done pulses WIDTH+1 cycles after start.
// No backpressure: start is honoured only in IDLE and ignored (not queued) while RUN or DONE.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] first,
   input  logic [WIDTH-1:0] second,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             br_next;

   full_subtractor_bit u_cell (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (br),
      .d    (d),
      .bout (br_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         diff  <= '0;
         bout  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh  <= first;
                  b_sh  <= second;
                  br    <= bin;
                  cnt   <= '0;
                  diff  <= '0;
                  bout  <= 1'b0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               diff <= {d, diff[WIDTH-1:1]};
               br   <= br_next;
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  bout  <= br_next;
                  state <= S_DONE;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] first;
   logic [WIDTH-1:0] second;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   int n_cmp = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .first  (first),
      .second (second),
      .bin    (bin),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .bout   (bout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer subtraction, borrow-out is the sign of the exact result.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] f, input logic [WIDTH-1:0] s,
                                            input logic b);
      int r;
      logic [WIDTH-1:0] dv;
      r  = int'(f) - int'(s) - int'(b);
      dv = WIDTH'(r);
      return {(r < 0), dv};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [WIDTH-1:0] f, input logic [WIDTH-1:0] s, input logic b,
                        input string tag);
      logic [WIDTH:0] exp;
      int n;
      exp = model(f, s, b);
      @(negedge clk);
      first = f; second = s; bin = b; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 3 * WIDTH) begin
         check({tag, "_busy"}, busy, 1);
         tick();
         n++;
      end
      check({tag, "_latency"}, n, WIDTH);
      check({tag, "_diff"}, diff, exp[WIDTH-1:0]);
      check({tag, "_bout"}, bout, exp[WIDTH]);
      tick();
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_diff_hold"}, diff, exp[WIDTH-1:0]);
   endtask

   initial begin
      int done_cnt;
      int done_at;
      int last_done;
      int n_done;
      logic seen_done;
      logic [WIDTH-1:0] rf, rs;
      logic rb;

      rst_n = 1'b0; start = 1'b0; first = '0; second = '0; bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_bout", bout, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(8'h05, 8'h03, 1'b0, "d_05_03");
      do_op(8'h03, 8'h05, 1'b0, "d_03_05");
      do_op(8'h80, 8'h01, 1'b0, "d_80_01");
      do_op(8'h00, 8'h00, 1'b1, "d_00_00_b");
      do_op(8'hFF, 8'hFF, 1'b1, "d_FF_FF_b");

      // A second start during RUN must be dropped entirely.
      @(negedge clk);
      first = 8'h05; second = 8'h03; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      done_cnt = 0; done_at = -1;
      for (int c = 1; c <= 24; c++) begin
         if (c == 3) begin
            first = 8'h11; second = 8'h01; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = c;
               check("ign_diff", diff, 8'h02);
               check("ign_bout", bout, 0);
            end
         end
      end
      check("ign_done_count", done_cnt, 1);
      check("ign_done_edge", done_at, WIDTH);
      check("ign_idle_busy", busy, 0);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      first = 8'h77; second = 8'h12; bin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("mid_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_diff", diff, 0);
      check("mid_rst_bout", bout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'h0A, 8'h04, 1'b0, "post_rst");

      // start held high: one operation every WIDTH+2 cycles.
      @(negedge clk);
      first = 8'h10; second = 8'h01; bin = 1'b0; start = 1'b1;
      last_done = -1; n_done = 0; seen_done = 1'b0;
      for (int c = 0; c < 45; c++) begin
         tick();
         if (done) begin
            check("b2b_diff", diff, 8'h0F);
            check("b2b_bout", bout, 0);
            if (last_done >= 0) check("b2b_period", c - last_done, WIDTH + 2);
            last_done = c;
            n_done++;
            seen_done = 1'b1;
         end else if (seen_done && !busy) begin
            check("b2b_hold", diff, 8'h0F);
            seen_done = 1'b0;
         end else begin
            seen_done = 1'b0;
         end
      end
      check("b2b_count", n_done >= 3, 1);
      start = 1'b0;
      repeat (WIDTH + 4) tick();
      check("b2b_idle", busy, 0);

      for (int i = 0; i < 16; i++) begin
         rf = WIDTH'($urandom);
         rs = WIDTH'($urandom);
         rb = 1'($urandom_range(0, 1));
         do_op(rf, rs, rb, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
